uart_frame_gen: RTL and testbench
=================================

Name: uart_frame_gen

Overview:
- Synthesizable UART frame generator. Serialises a small buffered burst of command/data bytes onto a UART line.
- Per-burst configuration: prescale, parity mode, stop-bit count and inter-frame gap. Per-frame parity-error and framing-error injection.
- Drives RX_IN of the system UART for on-chip loopback/BIST. Replays register-file and ALU command sequences without an external host.

Parameters:
- DATA_WIDTH, 8, data bits per frame.
- DEPTH, 4, maximum frames per burst (buffer entries).
- PRESCALE_W, 6, width of CFG_PRESCALE.
- GAP_W, 4, width of CFG_GAP.

Ports:
- CLK  in  1  single clock.
- RST  in  1  synchronous reset, active-low.
- CFG_PRESCALE  in  PRESCALE_W  CLK cycles per bit; 0 is treated as 1.
- CFG_PAR_EN  in  1  parity bit present.
- CFG_PAR_TYP  in  1  0 = even, 1 = odd.
- CFG_STOP2  in  1  two stop bits.
- CFG_GAP  in  GAP_W  idle bit-periods between frames.
- WR_EN  in  1  push one entry into the buffer.
- WR_DATA  in  DATA_WIDTH  frame payload.
- WR_INJ  in  2  bit0 = invert parity, bit1 = drive first stop bit low.
- START  in  1  begin transmitting the buffered burst.
- TX_OUT  out  1  serial line, idle high.
- BUSY  out  1  burst in progress.
- DONE  out  1  one-cycle pulse at burst end.
- BUF_CNT  out  clog2(DEPTH+1)  entries held.
- BUF_FULL  out  1  BUF_CNT == DEPTH.

Behaviour:
- Reset (RST low at a CLK edge):
  - TX_OUT=1, BUSY=0, DONE=0, BUF_CNT=0, BUF_FULL=0; FSM in IDLE.
  - Applies mid-burst: the line returns high immediately, no DONE pulse, buffer discarded.
- Buffer writes:
  - Accepted only in IDLE with BUF_CNT<DEPTH. Each write stores {WR_INJ, WR_DATA} at index BUF_CNT and increments BUF_CNT.
  - WR_EN while BUSY or full is ignored; no state change.
- Burst start:
  - START in IDLE with BUF_CNT>0 (counting a write accepted in the same cycle) latches all CFG_* inputs for the whole burst and enters START_BIT.
  - START with an empty buffer, or while BUSY, is ignored.
  - BUSY rises and TX_OUT=0 in the cycle after the START edge.
- FSM states and line levels:
  - IDLE: TX_OUT=1.
  - START_BIT: TX_OUT=0.
  - DATA: LSB first, DATA_WIDTH bits.
  - PARITY: only if PAR_EN. Value = XOR of data (even) or its inverse (odd), then XOR WR_INJ[0].
  - STOP: 1 or 2 bits. First stop bit = ~WR_INJ[1]; second stop bit is always 1.
  - GAP: TX_OUT=1 for CFG_GAP bit periods. Only entered between frames; skipped when CFG_GAP=0 (back-to-back frames).
- Bit timing:
  - Every bit lasts exactly P = max(CFG_PRESCALE, 1) cycles, timed by a down-counter reloaded at each bit boundary.
  - Frame length = (1 + DATA_WIDTH + PAR_EN + 1 + STOP2) × P cycles.
- Burst progress:
  - Frame index increments after each frame's final stop bit.
  - After the last frame (index == BUF_CNT-1) there is no trailing gap. DONE pulses for one cycle, BUSY falls in that same cycle, BUF_CNT clears to 0, FSM returns to IDLE.
- TX_OUT is registered and glitch-free; its value changes only at bit boundaries.
- WR_INJ[0] has no effect when PAR_EN=0.
- CFG_* changes during BUSY have no effect on the current burst.

Test Plan:
- Single even-parity frame:
  - Stimulus: P=4, PAR_EN=1, TYP=0, STOP2=0, push 0xAA, START.
  - Required: TX_OUT = 0,0,1,0,1,0,1,0,1,0,1, each held 4 cycles (44 cycles). DONE pulses in the cycle after the last stop period; BUF_CNT=0.
- Four-frame command burst:
  - Stimulus: push 0xCC, 0x56, 0x34, 0x00; GAP=2, P=2.
  - Required: four 11-bit frames with 4 idle-high cycles between frames. Exactly one DONE pulse, 4×22+3×4=100 cycles after TX_OUT first falls.
- Error injection and odd parity:
  - Stimulus: push 0x12 with WR_INJ=01, then 0x05 with WR_INJ=10; TYP=1.
  - Required: frame 1 parity bit = 0 (odd parity 1, inverted). Frame 2 first stop bit = 0.
- Boundaries:
  - Stimulus: 5 pushes with DEPTH=4; START with empty buffer; WR_EN+START in the same cycle with an empty buffer; CFG_PRESCALE=0.
  - Required: BUF_FULL=1 and the 5th push is dropped. Empty START gives BUSY=0. Same-cycle write is transmitted. Prescale 0 gives 1-cycle bits.
- Format options:
  - Stimulus: PAR_EN=0, STOP2=1, P=3, push 0xFF.
  - Required: 11-bit frame (start, 8 ones, 2 stop ones) = 33 cycles.
- Mid-burst reset:
  - Stimulus: RST low during the DATA state of frame 2.
  - Required: TX_OUT=1 next cycle, BUSY=0, BUF_CNT=0, no DONE. A subsequent START is ignored until new writes.

Source files
------------

// File: rtl/uart_frame_gen_if.sv
// Signal bundle between a burst source and the UART frame generator.
// It carries the burst configuration, the buffer write port, start, and the line/status outputs.
interface uart_frame_gen_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int PRESCALE_W = 6,
  parameter int GAP_W      = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PRESCALE_W-1:0] CFG_PRESCALE;
  logic                  CFG_PAR_EN;
  logic                  CFG_PAR_TYP;
  logic                  CFG_STOP2;
  logic [GAP_W-1:0]      CFG_GAP;
  logic                  WR_EN;
  logic [DATA_WIDTH-1:0] WR_DATA;
  logic [1:0]            WR_INJ;
  logic                  START;
  logic                  TX_OUT;
  logic                  BUSY;
  logic                  DONE;
  logic [CNT_W-1:0]      BUF_CNT;
  logic                  BUF_FULL;

  modport master (
    output CFG_PRESCALE, CFG_PAR_EN, CFG_PAR_TYP, CFG_STOP2, CFG_GAP,
    output WR_EN, WR_DATA, WR_INJ, START,
    input  TX_OUT, BUSY, DONE, BUF_CNT, BUF_FULL
  );

  modport slave (
    input  CFG_PRESCALE, CFG_PAR_EN, CFG_PAR_TYP, CFG_STOP2, CFG_GAP,
    input  WR_EN, WR_DATA, WR_INJ, START,
    output TX_OUT, BUSY, DONE, BUF_CNT, BUF_FULL
  );
endinterface

// File: rtl/uart_frame_gen.sv
// UART frame generator: buffers a short burst of bytes, then serialises them onto an
// idle-high line using the configuration captured at START, with optional error injection.
module uart_frame_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int PRESCALE_W = 6,
  parameter int GAP_W      = 4
) (
  input  logic            CLK,
  input  logic            RST,
  uart_frame_gen_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int ENT_W = DATA_WIDTH + 2;

  typedef enum logic [2:0] {
    IDLE,
    START_BIT,
    DATA,
    PARITY,
    STOP,
    GAP
  } state_t;

  state_t                state_r, state_nx;
  logic [PRESCALE_W-1:0] cnt_r, cnt_nx;
  logic [BIT_W-1:0]      bit_idx_r, bit_idx_nx;
  logic [IDX_W-1:0]      frame_idx_r, frame_idx_nx;
  logic                  stop_second_r, stop_second_nx;
  logic [GAP_W-1:0]      gap_cnt_r, gap_cnt_nx;
  logic                  tx_r, tx_nx;
  logic                  busy_r, busy_nx;
  logic                  done_r, done_nx;
  logic [CNT_W-1:0]      buf_cnt_r, buf_cnt_nx;

  logic [PRESCALE_W-1:0] reload_lat;
  logic                  par_en_lat;
  logic                  par_typ_lat;
  logic                  stop2_lat;
  logic [GAP_W-1:0]      gap_lat;

  logic [ENT_W-1:0]      mem [DEPTH];

  logic                  wr_accept;
  logic                  start_go;
  logic [PRESCALE_W-1:0] cfg_reload;
  logic [ENT_W-1:0]      cur_entry;
  logic [DATA_WIDTH-1:0] cur_data;
  logic [1:0]            cur_inj;
  logic                  parity_bit;
  logic                  last_frame;
  logic                  bit_end;
  logic [BIT_W-1:0]      bit_idx_inc;

  // A zero prescale still needs one cycle per bit, so the reload value saturates at zero.
  assign cfg_reload = (bus.CFG_PRESCALE == '0) ? '0 : bus.CFG_PRESCALE - PRESCALE_W'(1);

  assign wr_accept   = bus.WR_EN && (state_r == IDLE) && (buf_cnt_r < CNT_W'(DEPTH));
  assign start_go    = bus.START && (state_r == IDLE) && ((buf_cnt_r != '0) || wr_accept);
  assign cur_entry   = mem[frame_idx_r];
  assign cur_data    = cur_entry[DATA_WIDTH-1:0];
  assign cur_inj     = cur_entry[ENT_W-1:DATA_WIDTH];
  assign parity_bit  = (^cur_data) ^ par_typ_lat ^ cur_inj[0];
  assign last_frame  = (CNT_W'(frame_idx_r) == (buf_cnt_r - CNT_W'(1)));
  assign bit_end     = (cnt_r == '0);
  assign bit_idx_inc = bit_idx_r + BIT_W'(1);

  // Next-state and next-line-level logic; every line change is computed here and registered.
  always_comb begin
    state_nx       = state_r;
    cnt_nx         = cnt_r;
    bit_idx_nx     = bit_idx_r;
    frame_idx_nx   = frame_idx_r;
    stop_second_nx = stop_second_r;
    gap_cnt_nx     = gap_cnt_r;
    tx_nx          = tx_r;
    busy_nx        = busy_r;
    done_nx        = 1'b0;
    buf_cnt_nx     = buf_cnt_r;

    if (state_r != IDLE) begin
      cnt_nx = bit_end ? reload_lat : cnt_r - PRESCALE_W'(1);
    end

    unique case (state_r)
      IDLE: begin
        tx_nx   = 1'b1;
        busy_nx = 1'b0;
        if (wr_accept) begin
          buf_cnt_nx = buf_cnt_r + CNT_W'(1);
        end
        if (start_go) begin
          state_nx     = START_BIT;
          tx_nx        = 1'b0;
          busy_nx      = 1'b1;
          cnt_nx       = cfg_reload;
          frame_idx_nx = '0;
        end
      end
      START_BIT: begin
        if (bit_end) begin
          state_nx   = DATA;
          bit_idx_nx = '0;
          tx_nx      = cur_data[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx_r == BIT_W'(DATA_WIDTH - 1)) begin
            stop_second_nx = 1'b0;
            if (par_en_lat) begin
              state_nx = PARITY;
              tx_nx    = parity_bit;
            end else begin
              state_nx = STOP;
              tx_nx    = ~cur_inj[1];
            end
          end else begin
            bit_idx_nx = bit_idx_inc;
            tx_nx      = cur_data[bit_idx_inc];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_nx       = STOP;
          stop_second_nx = 1'b0;
          tx_nx          = ~cur_inj[1];
        end
      end
      STOP: begin
        if (bit_end) begin
          if (stop2_lat && !stop_second_r) begin
            stop_second_nx = 1'b1;
            tx_nx          = 1'b1;
          end else if (last_frame) begin
            state_nx   = IDLE;
            tx_nx      = 1'b1;
            busy_nx    = 1'b0;
            done_nx    = 1'b1;
            buf_cnt_nx = '0;
          end else begin
            frame_idx_nx = frame_idx_r + IDX_W'(1);
            if (gap_lat != '0) begin
              state_nx   = GAP;
              gap_cnt_nx = gap_lat - GAP_W'(1);
              tx_nx      = 1'b1;
            end else begin
              state_nx = START_BIT;
              tx_nx    = 1'b0;
            end
          end
        end
      end
      GAP: begin
        if (bit_end) begin
          if (gap_cnt_r == '0) begin
            state_nx = START_BIT;
            tx_nx    = 1'b0;
          end else begin
            gap_cnt_nx = gap_cnt_r - GAP_W'(1);
          end
        end
      end
      default: begin
        state_nx = IDLE;
        tx_nx    = 1'b1;
        busy_nx  = 1'b0;
      end
    endcase
  end

  // Control registers; reset drops the burst and returns the line high on the next edge.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_r       <= IDLE;
      cnt_r         <= '0;
      bit_idx_r     <= '0;
      frame_idx_r   <= '0;
      stop_second_r <= 1'b0;
      gap_cnt_r     <= '0;
      tx_r          <= 1'b1;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      buf_cnt_r     <= '0;
      reload_lat    <= '0;
      par_en_lat    <= 1'b0;
      par_typ_lat   <= 1'b0;
      stop2_lat     <= 1'b0;
      gap_lat       <= '0;
    end else begin
      state_r       <= state_nx;
      cnt_r         <= cnt_nx;
      bit_idx_r     <= bit_idx_nx;
      frame_idx_r   <= frame_idx_nx;
      stop_second_r <= stop_second_nx;
      gap_cnt_r     <= gap_cnt_nx;
      tx_r          <= tx_nx;
      busy_r        <= busy_nx;
      done_r        <= done_nx;
      buf_cnt_r     <= buf_cnt_nx;
      if (start_go) begin
        reload_lat  <= cfg_reload;
        par_en_lat  <= bus.CFG_PAR_EN;
        par_typ_lat <= bus.CFG_PAR_TYP;
        stop2_lat   <= bus.CFG_STOP2;
        gap_lat     <= bus.CFG_GAP;
      end
    end
  end

  // Buffer contents are only meaningful below BUF_CNT, so the storage itself is not reset.
  always_ff @(posedge CLK) begin
    if (RST && wr_accept) begin
      mem[buf_cnt_r[IDX_W-1:0]] <= {bus.WR_INJ, bus.WR_DATA};
    end
  end

  assign bus.TX_OUT   = tx_r;
  assign bus.BUSY     = busy_r;
  assign bus.DONE     = done_r;
  assign bus.BUF_CNT  = buf_cnt_r;
  assign bus.BUF_FULL = (buf_cnt_r == CNT_W'(DEPTH));

endmodule

// File: tb/tb_uart_frame_gen.sv
// Bench for uart_frame_gen: directed and random bursts, each checked cycle by cycle
// against a waveform built from the frame format rules.
module tb_uart_frame_gen;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] m_data[$];
  logic [1:0]    m_inj[$];
  bit            exp_q[$];

  uart_frame_gen_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PRESCALE_W(6), .GAP_W(4)) bus();

  uart_frame_gen #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PRESCALE_W(6), .GAP_W(4)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic apply_stimulus(input int p, input bit par_en, input bit typ,
                                input bit stop2, input int gap);
    bus.CFG_PRESCALE = 6'(p);
    bus.CFG_PAR_EN   = par_en;
    bus.CFG_PAR_TYP  = typ;
    bus.CFG_STOP2    = stop2;
    bus.CFG_GAP      = 4'(gap);
  endtask

  task automatic push(input logic [DW-1:0] d, input logic [1:0] inj);
    bus.WR_EN   = 1'b1;
    bus.WR_DATA = d;
    bus.WR_INJ  = inj;
    tick();
    bus.WR_EN = 1'b0;
    if (m_data.size() < DEPTH) begin
      m_data.push_back(d);
      m_inj.push_back(inj);
    end
    check_output("buf_cnt_after_push", 32'(bus.BUF_CNT), 32'(m_data.size()));
  endtask

  // The expected line: every frame expanded to bits, each bit held P cycles, gaps between frames.
  function automatic void build_expected();
    int p;
    int gap;
    bit b[$];
    exp_q.delete();
    p   = (bus.CFG_PRESCALE == 0) ? 1 : int'(bus.CFG_PRESCALE);
    gap = int'(bus.CFG_GAP);
    for (int f = 0; f < m_data.size(); f++) begin
      b.delete();
      b.push_back(1'b0);
      for (int i = 0; i < DW; i++) b.push_back(m_data[f][i]);
      if (bus.CFG_PAR_EN) b.push_back((^m_data[f]) ^ bus.CFG_PAR_TYP ^ m_inj[f][0]);
      b.push_back(!m_inj[f][1]);
      if (bus.CFG_STOP2) b.push_back(1'b1);
      foreach (b[i]) for (int r = 0; r < p; r++) exp_q.push_back(b[i]);
      if (f != m_data.size() - 1)
        for (int r = 0; r < gap * p; r++) exp_q.push_back(1'b1);
    end
  endfunction

  // Starts the burst and follows it; a non-negative stop_at leaves the burst running at that cycle.
  task automatic run_burst(input bit disturb, input int stop_at);
    int n;
    build_expected();
    n = exp_q.size();
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    bus.WR_EN = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (k > 0) tick();
      check_output($sformatf("tx_cycle_%0d", k), 32'(bus.TX_OUT), 32'(exp_q[k]));
      if (k == 0) begin
        check_output("busy_rise", 32'(bus.BUSY), 32'd1);
        if (disturb) begin
          apply_stimulus($urandom_range(0, 63), $urandom_range(0, 1), $urandom_range(0, 1),
                         $urandom_range(0, 1), $urandom_range(0, 15));
          bus.WR_EN   = 1'b1;
          bus.WR_DATA = 8'($urandom);
          bus.WR_INJ  = 2'($urandom);
        end
      end
      if (k == n - 1) begin
        check_output("busy_last", 32'(bus.BUSY), 32'd1);
        check_output("done_early", 32'(bus.DONE), 32'd0);
      end
      if (k == stop_at) return;
    end
    tick();
    check_output("done_pulse", 32'(bus.DONE), 32'd1);
    check_output("busy_fall", 32'(bus.BUSY), 32'd0);
    check_output("buf_cnt_clear", 32'(bus.BUF_CNT), 32'd0);
    check_output("tx_idle", 32'(bus.TX_OUT), 32'd1);
    bus.WR_EN = 1'b0;
    m_data.delete();
    m_inj.delete();
    tick();
    check_output("done_one_cycle", 32'(bus.DONE), 32'd0);
  endtask

  initial begin
    int n;
    bus.WR_EN   = 1'b0;
    bus.WR_DATA = '0;
    bus.WR_INJ  = '0;
    bus.START   = 1'b0;
    apply_stimulus(4, 1'b1, 1'b0, 1'b0, 0);

    RST = 1'b0;
    repeat (3) tick();
    check_output("rst_tx", 32'(bus.TX_OUT), 32'd1);
    check_output("rst_busy", 32'(bus.BUSY), 32'd0);
    check_output("rst_done", 32'(bus.DONE), 32'd0);
    check_output("rst_buf_cnt", 32'(bus.BUF_CNT), 32'd0);
    check_output("rst_buf_full", 32'(bus.BUF_FULL), 32'd0);
    RST = 1'b1;
    tick();

    $display("[TB] single even-parity frame");
    apply_stimulus(4, 1'b1, 1'b0, 1'b0, 0);
    push(8'hAA, 2'b00);
    run_burst(1'b0, -1);

    $display("[TB] four-frame burst, config and writes disturbed while busy");
    apply_stimulus(2, 1'b1, 1'b0, 1'b0, 2);
    push(8'hCC, 2'b00);
    push(8'h56, 2'b00);
    push(8'h34, 2'b00);
    push(8'h00, 2'b00);
    run_burst(1'b1, -1);

    $display("[TB] error injection with odd parity");
    apply_stimulus(3, 1'b1, 1'b1, 1'b0, 1);
    push(8'h12, 2'b01);
    push(8'h05, 2'b10);
    run_burst(1'b0, -1);

    $display("[TB] boundaries");
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    check_output("empty_start_busy", 32'(bus.BUSY), 32'd0);
    check_output("empty_start_tx", 32'(bus.TX_OUT), 32'd1);
    apply_stimulus(1, 1'b0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 5; i++) push(8'($urandom), 2'($urandom));
    check_output("buf_full", 32'(bus.BUF_FULL), 32'd1);
    run_burst(1'b0, -1);
    apply_stimulus(0, 1'b1, 1'b0, 1'b1, 0);
    bus.WR_EN   = 1'b1;
    bus.WR_DATA = 8'h3C;
    bus.WR_INJ  = 2'b00;
    m_data.push_back(8'h3C);
    m_inj.push_back(2'b00);
    run_burst(1'b0, -1);

    $display("[TB] no parity, two stop bits");
    apply_stimulus(3, 1'b0, 1'b0, 1'b1, 0);
    push(8'hFF, 2'b01);
    run_burst(1'b0, -1);

    $display("[TB] random bursts");
    for (int it = 0; it < 6; it++) begin
      apply_stimulus($urandom_range(0, 5), $urandom_range(0, 1), $urandom_range(0, 1),
                     $urandom_range(0, 1), $urandom_range(0, 3));
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) push(8'($urandom), 2'($urandom));
      run_burst(1'($urandom_range(0, 1)), -1);
    end

    $display("[TB] mid-burst reset");
    apply_stimulus(2, 1'b1, 1'b0, 1'b0, 1);
    push(8'h5A, 2'b00);
    push(8'hF0, 2'b00);
    run_burst(1'b0, 29);
    RST = 1'b0;
    tick();
    RST = 1'b1;
    check_output("mid_rst_tx", 32'(bus.TX_OUT), 32'd1);
    check_output("mid_rst_busy", 32'(bus.BUSY), 32'd0);
    check_output("mid_rst_buf_cnt", 32'(bus.BUF_CNT), 32'd0);
    check_output("mid_rst_done", 32'(bus.DONE), 32'd0);
    m_data.delete();
    m_inj.delete();
    tick();
    check_output("post_rst_done", 32'(bus.DONE), 32'd0);
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    check_output("post_rst_start_busy", 32'(bus.BUSY), 32'd0);
    check_output("post_rst_start_tx", 32'(bus.TX_OUT), 32'd1);
    push(8'h81, 2'b00);
    run_burst(1'b0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
